// File: rtl/cavlc_coeff_scan_pkg.sv
// cavlc_pkg: shared types and constants for the CAVLC coefficient scanner.
//   mode_t         block type selector (reserved encoding behaves as LUMA4x4)
//   state_t        scanner FSM states
//   ZIGZAG_LUT     scan position -> raster index for 4x4 blocks
//   CHROMA_DC_LUT  scan position -> raster index for 2x2 chroma DC
//   N_*            coefficient count per mode
package cavlc_pkg;

    typedef enum logic [1:0] {
        MODE_LUMA4X4   = 2'd0,
        MODE_AC        = 2'd1,
        MODE_CHROMA_DC = 2'd2,
        MODE_RSVD      = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [3:0] ZIGZAG_LUT [16] = '{
        4'd0, 4'd1, 4'd4, 4'd8, 4'd5, 4'd2, 4'd3, 4'd6,
        4'd9, 4'd12, 4'd13, 4'd10, 4'd7, 4'd11, 4'd14, 4'd15
    };

    localparam logic [3:0] CHROMA_DC_LUT [4] = '{4'd0, 4'd1, 4'd4, 4'd5};

    localparam int unsigned N_LUMA4X4   = 16;
    localparam int unsigned N_AC        = 15;
    localparam int unsigned N_CHROMA_DC = 4;

    // Lowest scan index examined (AC blocks skip the DC term)
    function automatic logic [3:0] first_idx(input mode_t m);
        return (m == MODE_AC) ? 4'd1 : 4'd0;
    endfunction

    // Highest scan index examined; scanning runs from here down to first_idx
    function automatic logic [3:0] start_idx(input mode_t m);
        case (m)
            MODE_AC:        return 4'(1 + N_AC - 1);
            MODE_CHROMA_DC: return 4'(N_CHROMA_DC - 1);
            default:        return 4'(N_LUMA4X4 - 1);
        endcase
    endfunction

endpackage

// File: rtl/cavlc_coeff_scan_if.sv
// cavlc_coeff_scan_if: block-in / summary-out handshake bundle.
//   valid_i/ready_o  block offer/accept, with mode_i and raster coeff_i
//   valid_o/ready_i  summary offer/consume, with total_coeff_o,
//                    trailing_ones_o, t1_sign_o, total_zeros_o
//   With CAVLC_SCAN_LEVEL_OUT_EN: lvl_valid_o, level_o, run_before_o.
//   master = block producer / result consumer, slave = scanner.
interface cavlc_coeff_scan_if #(
    parameter int COEFF_W = 8
);
    logic                      valid_i;
    logic                      ready_o;
    logic [1:0]                mode_i;
    logic [15:0][COEFF_W-1:0]  coeff_i;
    logic                      valid_o;
    logic                      ready_i;
    logic [4:0]                total_coeff_o;
    logic [1:0]                trailing_ones_o;
    logic [2:0]                t1_sign_o;
    logic [3:0]                total_zeros_o;
`ifdef CAVLC_SCAN_LEVEL_OUT_EN
    logic                      lvl_valid_o;
    logic [COEFF_W-1:0]        level_o;
    logic [3:0]                run_before_o;
`endif

    modport master (
        output valid_i, mode_i, coeff_i, ready_i,
        input  ready_o, valid_o, total_coeff_o, trailing_ones_o,
               t1_sign_o, total_zeros_o
`ifdef CAVLC_SCAN_LEVEL_OUT_EN
        , input lvl_valid_o, level_o, run_before_o
`endif
    );

    modport slave (
        input  valid_i, mode_i, coeff_i, ready_i,
        output ready_o, valid_o, total_coeff_o, trailing_ones_o,
               t1_sign_o, total_zeros_o
`ifdef CAVLC_SCAN_LEVEL_OUT_EN
        , output lvl_valid_o, level_o, run_before_o
`endif
    );

endinterface

// File: rtl/cavlc_coeff_scan_zigzag.sv
// cavlc_zigzag: combinational raster-to-scan reorder.
//   mode   block type (CHROMA_DC uses raster 0,1,4,5; others use zigzag)
//   coeff  16 raster-ordered coefficients
//   scan   coefficients in scan order (unused tail zeroed for CHROMA_DC)
import cavlc_pkg::*;

module cavlc_zigzag #(
    parameter int COEFF_W = 8
) (
    input  mode_t                     mode,
    input  logic [15:0][COEFF_W-1:0]  coeff,
    output logic [15:0][COEFF_W-1:0]  scan
);

    always_comb begin
        scan = '0;
        if (mode == MODE_CHROMA_DC) begin
            for (int unsigned i = 0; i < 4; i++)
                scan[i] = coeff[CHROMA_DC_LUT[i]];
        end else begin
            for (int unsigned i = 0; i < 16; i++)
                scan[i] = coeff[ZIGZAG_LUT[i]];
        end
    end

endmodule

// File: rtl/cavlc_coeff_scan.sv
// cavlc_coeff_scan: CAVLC summary scanner for one residual block.
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  cavlc_coeff_scan_if.slave (block in, summary out)
// Accepts a block in IDLE, walks it in reverse scan order one coefficient
// per cycle, then presents total_coeff / trailing_ones / t1_sign /
// total_zeros until consumed. Accept-to-valid_o latency is N+1 cycles.
// Optional macro CAVLC_SCAN_LEVEL_OUT_EN adds a per-nonzero level/run stream.
import cavlc_pkg::*;

module cavlc_coeff_scan #(
    parameter int COEFF_W = 8,
    parameter int RUN_W   = 4
) (
    input logic              clk,
    input logic              rst,
    cavlc_coeff_scan_if.slave bus
);

    state_t                    state;
    mode_t                     mode_q;
    mode_t                     mode_in;
    logic [15:0][COEFF_W-1:0]  scan_d;
    logic [15:0][COEFF_W-1:0]  scan_q;
    logic [3:0]                idx;
    logic [4:0]                total_coeff;
    logic [1:0]                t1_cnt;
    logic [2:0]                t1_sign;
    logic [RUN_W-1:0]          total_zeros;
    logic                      seen_nz;
    logic                      seen_big;
    logic                      valid_q;
    logic [COEFF_W-1:0]        cur;
    logic                      cur_nz;
    logic                      cur_one;
    logic                      last;

    assign mode_in = (bus.mode_i == MODE_RSVD) ? MODE_LUMA4X4 : mode_t'(bus.mode_i);

    cavlc_zigzag #(.COEFF_W(COEFF_W)) u_zigzag (
        .mode  (mode_in),
        .coeff (bus.coeff_i),
        .scan  (scan_d)
    );

    assign cur     = scan_q[idx];
    assign cur_nz  = |cur;
    // +1 or -1 only; the most negative value is never all-ones so it counts as big
    assign cur_one = (cur == {{(COEFF_W-1){1'b0}}, 1'b1}) || (&cur);
    assign last    = (idx == first_idx(mode_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mode_q      <= MODE_LUMA4X4;
            scan_q      <= '0;
            idx         <= '0;
            total_coeff <= '0;
            t1_cnt      <= '0;
            t1_sign     <= '0;
            total_zeros <= '0;
            seen_nz     <= 1'b0;
            seen_big    <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.valid_i) begin
                        scan_q      <= scan_d;
                        mode_q      <= mode_in;
                        idx         <= start_idx(mode_in);
                        total_coeff <= '0;
                        t1_cnt      <= '0;
                        t1_sign     <= '0;
                        total_zeros <= '0;
                        seen_nz     <= 1'b0;
                        seen_big    <= 1'b0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (cur_nz) begin
                        total_coeff <= total_coeff + 5'd1;
                        seen_nz     <= 1'b1;
                        if (!cur_one) begin
                            seen_big <= 1'b1;
                        end else if (!seen_big && t1_cnt != 2'd3) begin
                            case (t1_cnt)
                                2'd0:    t1_sign[0] <= cur[COEFF_W-1];
                                2'd1:    t1_sign[1] <= cur[COEFF_W-1];
                                default: t1_sign[2] <= cur[COEFF_W-1];
                            endcase
                            t1_cnt <= t1_cnt + 2'd1;
                        end
                    end else if (seen_nz) begin
                        total_zeros <= total_zeros + {{(RUN_W-1){1'b0}}, 1'b1};
                    end
                    if (last)
                        state <= DONE;
                    else
                        idx <= idx - 4'd1;
                end
                DONE: begin
                    // First DONE cycle only raises valid_o, giving N+1 latency
                    // and a slot for the final level pulse ahead of valid_o.
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (bus.ready_i) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ready_o         = (state == IDLE);
    assign bus.valid_o         = valid_q;
    assign bus.total_coeff_o   = total_coeff;
    assign bus.trailing_ones_o = t1_cnt;
    assign bus.t1_sign_o       = t1_sign;
    assign bus.total_zeros_o   = total_zeros;

`ifdef CAVLC_SCAN_LEVEL_OUT_EN
    // Each nonzero is held pending until the next lower nonzero is examined
    // (or the scan ends) so that its run_before is known when emitted.
    logic               pend_v;
    logic [COEFF_W-1:0] pend_lvl;
    logic [RUN_W-1:0]   run_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_v   <= 1'b0;
            pend_lvl <= '0;
            run_cnt  <= '0;
        end else if (state == IDLE && bus.valid_i) begin
            pend_v  <= 1'b0;
            run_cnt <= '0;
        end else if (state == SCAN) begin
            if (cur_nz) begin
                pend_v   <= 1'b1;
                pend_lvl <= cur;
                run_cnt  <= '0;
            end else if (pend_v) begin
                run_cnt <= run_cnt + {{(RUN_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign bus.lvl_valid_o  = pend_v && ((state == SCAN && cur_nz) || (state == DONE && !valid_q));
    assign bus.level_o      = pend_lvl;
    assign bus.run_before_o = run_cnt;
`endif

endmodule

// File: tb/tb_cavlc_coeff_scan.sv
module tb_cavlc_coeff_scan;

    localparam int W = 8;

    typedef logic [15:0][W-1:0] blk_t;
    typedef struct {
        int tc;
        int t1;
        int sg;
        int tz;
        int lat;
        int acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    bit   vprev = 1'b0;

    cavlc_coeff_scan_if #(.COEFF_W(W)) bus();

    cavlc_coeff_scan #(.COEFF_W(W), .RUN_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic blk_t mk(input int v[16]);
        blk_t b;
        for (int i = 0; i < 16; i++) b[i] = W'(v[i]);
        return b;
    endfunction

    // Scoreboard monitor: pops on the first cycle of each valid_o assertion
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.valid_o && !vprev) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid_o=1 expected no result (cycle %0d)", cyc);
            end else begin
                e = sb.pop_front();
                chk("total_coeff",   int'(bus.total_coeff_o),   e.tc);
                chk("trailing_ones", int'(bus.trailing_ones_o), e.t1);
                chk("t1_sign",       int'(bus.t1_sign_o),       e.sg);
                chk("total_zeros",   int'(bus.total_zeros_o),   e.tz);
                chk("latency",       cyc - e.acc,               e.lat);
            end
        end
        vprev = bus.valid_o;
    end

`ifdef CAVLC_SCAN_LEVEL_OUT_EN
    int lq_lvl[$];
    int lq_run[$];
    always @(negedge clk) begin
        if (!rst && bus.lvl_valid_o) begin
            lq_lvl.push_back(int'($signed(bus.level_o)));
            lq_run.push_back(int'(bus.run_before_o));
        end
    end
`endif

    task automatic send(input logic [1:0] m, input blk_t c, input exp_t e_in, input bit push);
        exp_t e = e_in;
        int guard = 0;
        @(negedge clk);
        while (!bus.ready_o && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.ready_o) begin
            chk("send_ready_timeout", int'(bus.ready_o), 1);
            return;
        end
        bus.mode_i  = m;
        bus.coeff_i = c;
        bus.valid_i = 1'b1;
        e.acc = cyc + 1;
        if (push) sb.push_back(e);
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || bus.valid_o) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
    endtask

    function automatic exp_t mkexp(input int tc, t1, sg, tz, lat);
        exp_t e;
        e.tc = tc; e.t1 = t1; e.sg = sg; e.tz = tz; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   v[16];
        blk_t b_main;
        exp_t e_main;

        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        bus.mode_i  = 2'd0;
        bus.coeff_i = '0;

        repeat (3) @(negedge clk);
        chk("rst_valid_o",     int'(bus.valid_o), 0);
        chk("rst_total_coeff", int'(bus.total_coeff_o), 0);
        chk("rst_t1",          int'(bus.trailing_ones_o), 0);
        chk("rst_t1_sign",     int'(bus.t1_sign_o), 0);
        chk("rst_total_zeros", int'(bus.total_zeros_o), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_o", int'(bus.ready_o), 1);

        // Main LUMA4x4 block
        v = '{-12, 7, 0, 1,  7, 1, -3, 0,  0, -5, -3, 0,  0, -2, 2, 1};
        b_main = mk(v);
        e_main = mkexp(11, 1, 0, 5, 17);
`ifdef CAVLC_SCAN_LEVEL_OUT_EN
        lq_lvl.delete();
        lq_run.delete();
`endif
        send(2'd0, b_main, e_main, 1'b1);
        wait_drain();
`ifdef CAVLC_SCAN_LEVEL_OUT_EN
        chk("lvl_pulses", lq_lvl.size(), 11);
        if (lq_lvl.size() >= 11) begin
            chk("lvl0_level", lq_lvl[0], 1);
            chk("lvl0_run",   lq_run[0], 0);
            chk("lvl1_level", lq_lvl[1], 2);
            chk("lvl1_run",   lq_run[1], 2);
            chk("lvl10_level", lq_lvl[10], -12);
            chk("lvl10_run",   lq_run[10], 0);
        end
`endif

        // All zero
        v = '{default: 0};
        send(2'd0, mk(v), mkexp(0, 0, 0, 0, 17), 1'b1);
        // Only raster(3,3) = 1
        v = '{default: 0}; v[15] = 1;
        send(2'd0, mk(v), mkexp(1, 1, 0, 15, 17), 1'b1);
        // Only raster(0,0) = -1
        v = '{default: 0}; v[0] = -1;
        send(2'd0, mk(v), mkexp(1, 1, 1, 0, 17), 1'b1);
        // CHROMA_DC; raster 2 and 15 must be ignored
        v = '{default: 0}; v[0] = -1; v[1] = 1; v[4] = 0; v[5] = 1; v[2] = 9; v[15] = 3;
        send(2'd2, mk(v), mkexp(3, 3, 4, 1, 5), 1'b1);
        // AC: DC term ignored
        v = '{default: 0}; v[0] = 50; v[15] = -1;
        send(2'd1, mk(v), mkexp(1, 1, 1, 14, 16), 1'b1);
        // Reserved mode behaves as LUMA4x4
        v = '{default: 0}; v[15] = 1;
        send(2'd3, mk(v), mkexp(1, 1, 0, 15, 17), 1'b1);
        // Most negative value counts as |c|>1
        v = '{default: 0}; v[15] = 1; v[14] = -128; v[11] = -1;
        send(2'd0, mk(v), mkexp(3, 1, 0, 13, 17), 1'b1);
        // Four ones: trailing-ones count caps at 3
        v = '{default: 0}; v[15] = -1; v[14] = 1; v[11] = -1; v[7] = 1;
        send(2'd0, mk(v), mkexp(4, 3, 5, 12, 17), 1'b1);
        wait_drain();

        // Backpressure: ready_i low 10 cycles, valid_i pulses ignored
        bus.ready_i = 1'b0;
        send(2'd0, b_main, e_main, 1'b1);
        begin
            int n = 0;
            while (!bus.valid_o && n < 100) begin
                @(negedge clk);
                n++;
            end
            chk("bp_valid_seen", int'(bus.valid_o), 1);
        end
        v = '{default: 0}; v[0] = 5;
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid_o",     int'(bus.valid_o), 1);
            chk("bp_ready_o",     int'(bus.ready_o), 0);
            chk("bp_total_coeff", int'(bus.total_coeff_o), 11);
            chk("bp_t1",          int'(bus.trailing_ones_o), 1);
            chk("bp_t1_sign",     int'(bus.t1_sign_o), 0);
            chk("bp_total_zeros", int'(bus.total_zeros_o), 5);
            bus.mode_i  = 2'd2;
            bus.coeff_i = mk(v);
            bus.valid_i = (i % 2 == 0);
            @(negedge clk);
        end
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        @(negedge clk);
        chk("bp_valid_drop", int'(bus.valid_o), 0);
        chk("bp_ready_back", int'(bus.ready_o), 1);
        repeat (30) @(negedge clk);

        // Reset at SCAN cycle 5: block discarded, new block accepted cleanly
        send(2'd0, b_main, e_main, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midscan_rst_valid", int'(bus.valid_o), 0);
        chk("midscan_rst_tc",    int'(bus.total_coeff_o), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midscan_rst_ready", int'(bus.ready_o), 1);
        repeat (25) @(negedge clk);
        v = '{default: 0}; v[0] = -1; v[1] = 1; v[5] = 1;
        send(2'd2, mk(v), mkexp(3, 3, 4, 1, 5), 1'b1);
        wait_drain();

        // Reset while in DONE: no valid_o pulse may escape
        bus.ready_i = 1'b0;
        send(2'd2, mk(v), mkexp(0, 0, 0, 0, 0), 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.ready_i = 1'b1;
        repeat (20) @(negedge clk);
        chk("done_rst_valid", int'(bus.valid_o), 0);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
